// File: rtl/pstatus_pkg.sv
// Shared constants and helpers for the multi-channel status register bank.
// The address space is split into two regions of NCH registers each:
// status registers first, then the per-channel interrupt masks.
package pstatus_pkg;

  localparam int STA_BASE = 0;
  localparam int NCH_MAX  = 16;

  // The mask region starts right after the NCH status registers.
  function automatic int msk_base(input int nch);
    return nch;
  endfunction

  // True when an address falls into either mapped region.
  function automatic logic addr_ok(input int unsigned a, input int unsigned nch);
    return a < 2 * nch;
  endfunction

  // The address bus must reach every status and mask register.
  function automatic logic aw_ok(input int aw, input int nch);
    return (aw >= 1) && (aw < 31) && ((1 << aw) >= 2 * nch);
  endfunction

  function automatic logic nch_ok(input int nch);
    return (nch >= 1) && (nch <= NCH_MAX);
  endfunction

endpackage

// File: rtl/pstatus_ch.sv
// One status channel: status register (live or sticky), its interrupt mask
// and the combinational interrupt term the top level ORs and registers.
module pstatus_ch
  import pstatus_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit STICKY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sta_in,
  input  logic             sta_vld,
  input  logic             rd_hit,
  input  logic             wr_sta_hit,
  input  logic             wr_msk_hit,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] sta_q,
  output logic [WIDTH-1:0] msk_q,
  output logic             irq_term
);

  logic [WIDTH-1:0] set_bits;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] sta_nxt;

  // Next status value: sticky channels clear what was read or written-1 and
  // then OR in new events, so an event arriving with a clear is never lost.
  always_comb begin
    set_bits = sta_vld ? sta_in : '0;
    clr_bits = (rd_hit ? sta_q : '0) | (wr_sta_hit ? wdata : '0);
    if (STICKY_EN) begin
      sta_nxt = (sta_q & ~clr_bits) | set_bits;
    end else begin
      sta_nxt = sta_vld ? sta_in : sta_q;
    end
  end

  // Status and mask registers; mask exists for live channels too.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sta_q <= '0;
      msk_q <= '0;
    end else begin
      sta_q <= sta_nxt;
      if (wr_msk_hit) begin
        msk_q <= wdata;
      end
    end
  end

  // Only sticky channels can raise an interrupt.
  assign irq_term = STICKY_EN && (|(sta_q & msk_q));

endmodule

// File: rtl/pstatus_bank.sv
// Multi-channel status register bank on the up* CPU bus.
// Bus handshake: an access is one cycle of upen with uprs (read) or upws
// (write); read wins if both selects are high. upack answers exactly one
// cycle later for every access, mapped or not, with no wait states, so
// back-to-back accesses are legal. sta_vld is a per-channel valid with no
// ready: the bank accepts every update in the cycle it is presented.
module pstatus_bank
  import pstatus_pkg::*;
#(
  parameter int             WIDTH  = 8,
  parameter int             NCH    = 4,
  parameter int             AW     = 5,
  parameter logic [NCH-1:0] STICKY = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] sta_in,
  input  logic [NCH-1:0]       sta_vld,
  input  logic                 upen,
  input  logic                 uprs,
  input  logic                 upws,
  input  logic [AW-1:0]        upa,
  input  logic [WIDTH-1:0]     updi,
  output logic [WIDTH-1:0]     updo,
  output logic                 upack,
  output logic                 irq
);

  if (!aw_ok(AW, NCH) || !nch_ok(NCH)) begin : g_bad_cfg
    $error("pstatus_bank: NCH must be 1..16 and 2**AW must cover 2*NCH registers");
  end

  logic             rd_en;
  logic             wr_en;
  logic [NCH-1:0]   irq_terms;
  logic [WIDTH-1:0] sta_q [NCH];
  logic [WIDTH-1:0] msk_q [NCH];
  logic [WIDTH-1:0] rd_data;

  assign rd_en = upen & uprs;
  assign wr_en = upen & upws & ~uprs;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pstatus_ch #(
      .WIDTH     (WIDTH),
      .STICKY_EN (STICKY[i])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .sta_in     (sta_in[i*WIDTH +: WIDTH]),
      .sta_vld    (sta_vld[i]),
      .rd_hit     (rd_en && (upa == AW'(STA_BASE + i))),
      .wr_sta_hit (wr_en && (upa == AW'(STA_BASE + i))),
      .wr_msk_hit (wr_en && (upa == AW'(msk_base(NCH) + i))),
      .wdata      (updi),
      .sta_q      (sta_q[i]),
      .msk_q      (msk_q[i]),
      .irq_term   (irq_terms[i])
    );
  end

  // Read mux over both regions; unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (32'(upa) == 32'(STA_BASE + i)) rd_data = sta_q[i];
      if (32'(upa) == 32'(msk_base(NCH) + i)) rd_data = msk_q[i];
    end
    if (!addr_ok(32'(upa), NCH)) rd_data = '0;
  end

  // Registered bus response and interrupt; updo holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      updo  <= '0;
      upack <= 1'b0;
      irq   <= 1'b0;
    end else begin
      upack <= rd_en | wr_en;
      if (rd_en) begin
        updo <= rd_data;
      end
      irq <= |irq_terms;
    end
  end

endmodule

// File: tb/tb_pstatus_bank.sv
// Bench for pstatus_bank: directed scenarios followed by random traffic, all
// checked against a register-level reference model held in arrays.
module tb_pstatus_bank;

  localparam int             WIDTH  = 8;
  localparam int             NCH    = 4;
  localparam int             AW     = 5;
  localparam logic [NCH-1:0] STICKY = 4'b0010;

  logic                 clk;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] sta_in;
  logic [NCH-1:0]       sta_vld;
  logic                 upen;
  logic                 uprs;
  logic                 upws;
  logic [AW-1:0]        upa;
  logic [WIDTH-1:0]     updi;
  logic [WIDTH-1:0]     updo;
  logic                 upack;
  logic                 irq;

  pstatus_bank #(
    .WIDTH  (WIDTH),
    .NCH    (NCH),
    .AW     (AW),
    .STICKY (STICKY)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sta_in  (sta_in),
    .sta_vld (sta_vld),
    .upen    (upen),
    .uprs    (uprs),
    .upws    (upws),
    .upa     (upa),
    .updi    (updi),
    .updo    (updo),
    .upack   (upack),
    .irq     (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  logic [WIDTH-1:0] m_sta [NCH];
  logic [WIDTH-1:0] m_msk [NCH];
  logic [WIDTH-1:0] m_updo;
  logic             m_ack;
  logic             m_irq;
  logic             m_rd_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register-level model: what each register holds after the coming edge.
  task automatic model_step();
    logic rd, wr;
    int a;
    logic [WIDTH-1:0] events, cleared;
    rd = upen && uprs;
    wr = upen && upws && !uprs;
    a  = int'(upa);
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_sta[i] = '0;
        m_msk[i] = '0;
      end
      m_updo = '0; m_ack = 1'b0; m_irq = 1'b0; m_rd_last = 1'b0;
      return;
    end
    m_ack = rd || wr;
    m_rd_last = rd;
    if (rd) begin
      if (a < NCH) m_updo = m_sta[a];
      else if (a < 2 * NCH) m_updo = m_msk[a - NCH];
      else m_updo = '0;
      exp_q.push_back(m_updo);
    end
    m_irq = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (STICKY[i] && ((m_sta[i] & m_msk[i]) != 0)) m_irq = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      events = sta_vld[i] ? sta_in[i*WIDTH +: WIDTH] : '0;
      if (STICKY[i]) begin
        cleared = '0;
        if (rd && a == i) cleared = m_sta[i];
        if (wr && a == i) cleared = cleared | updi;
        m_sta[i] = (m_sta[i] & ~cleared) | events;
      end else if (sta_vld[i]) begin
        m_sta[i] = events;
      end
      if (wr && a == NCH + i) m_msk[i] = updi;
    end
  endtask

  task automatic check_outputs();
    chk("upack", 32'(upack), 32'(m_ack));
    chk("irq", 32'(irq), 32'(m_irq));
    if (m_rd_last) begin
      if (exp_q.size() == 0) chk("rd_queued", 32'(exp_q.size()), 32'd1);
      else chk("rdata", 32'(updo), 32'(exp_q.pop_front()));
    end else begin
      chk("updo_hold", 32'(updo), 32'(m_updo));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic bus_idle();
    upen = 1'b0; uprs = 1'b0; upws = 1'b0;
  endtask

  task automatic bus_rd(input int a);
    upen = 1'b1; uprs = 1'b1; upws = 1'b0; upa = AW'(a);
    tick();
    bus_idle();
  endtask

  task automatic bus_wr(input int a, input logic [WIDTH-1:0] d);
    upen = 1'b1; uprs = 1'b0; upws = 1'b1; upa = AW'(a); updi = d;
    tick();
    bus_idle();
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] v, input logic vld);
    sta_in[ch*WIDTH +: WIDTH] = v;
    sta_vld[ch] = vld;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; sta_in = '0; sta_vld = '0;
    upen = 1'b0; uprs = 1'b0; upws = 1'b0; upa = '0; updi = '0;
    m_updo = '0; m_ack = 1'b0; m_irq = 1'b0; m_rd_last = 1'b0;
    for (int i = 0; i < NCH; i++) begin m_sta[i] = '0; m_msk[i] = '0; end

    tick(); tick();
    chk("rst_upack", 32'(upack), 32'd0);
    chk("rst_updo", 32'(updo), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    tick();

    // live channel 0 follows only while valid
    set_ch(0, 8'h5A, 1'b1); tick();
    set_ch(0, 8'hFF, 1'b0); tick();
    bus_rd(0);
    chk("live_rd", 32'(updo), 32'h5A);
    chk("live_ack", 32'(upack), 32'd1);
    bus_rd(0);
    chk("live_rd2", 32'(updo), 32'h5A);

    // sticky accumulate then read-to-clear
    set_ch(1, 8'h01, 1'b1); tick();
    set_ch(1, 8'h80, 1'b1); tick();
    set_ch(1, 8'h00, 1'b0);
    bus_rd(1);
    chk("sticky_acc", 32'(updo), 32'h81);
    bus_rd(1);
    chk("sticky_r2c", 32'(updo), 32'h00);

    // new event in the same cycle as read-to-clear survives
    set_ch(1, 8'h03, 1'b1); tick();
    set_ch(1, 8'h02, 1'b1);
    bus_rd(1);
    set_ch(1, 8'h00, 1'b0);
    chk("setwin_rd", 32'(updo), 32'h03);
    bus_rd(1);
    chk("setwin_rd2", 32'(updo), 32'h02);

    // write-1-to-clear and irq timing
    bus_wr(5, 8'h0F);
    set_ch(1, 8'h0C, 1'b1); tick();
    set_ch(1, 8'h00, 1'b0);
    chk("irq_not_yet", 32'(irq), 32'd0);
    tick();
    chk("irq_rise", 32'(irq), 32'd1);
    bus_wr(1, 8'h04);
    tick();
    chk("irq_stay", 32'(irq), 32'd1);
    bus_wr(1, 8'h08);
    chk("irq_lag", 32'(irq), 32'd1);
    tick();
    chk("irq_fall", 32'(irq), 32'd0);
    bus_rd(1);
    chk("w1c_empty", 32'(updo), 32'h00);

    // unmapped read, simultaneous selects, write to live status
    bus_rd(9);
    chk("unmapped_rd", 32'(updo), 32'h00);
    chk("unmapped_ack", 32'(upack), 32'd1);
    upen = 1'b1; uprs = 1'b1; upws = 1'b1; upa = AW'(5); updi = 8'hF0;
    tick();
    bus_idle();
    chk("both_sel_rd", 32'(updo), 32'h0F);
    bus_rd(5);
    chk("both_sel_msk", 32'(updo), 32'h0F);
    bus_wr(0, 8'h33);
    chk("live_wr_ack", 32'(upack), 32'd1);
    bus_rd(0);
    chk("live_wr_ign", 32'(updo), 32'h5A);

    // reset in the middle of a read of a sticky channel
    set_ch(1, 8'hAA, 1'b1); tick();
    set_ch(1, 8'h00, 1'b0);
    tick();
    rst_n = 1'b0;
    upen = 1'b1; uprs = 1'b1; upws = 1'b0; upa = AW'(1);
    tick();
    bus_idle();
    chk("rstmid_ack", 32'(upack), 32'd0);
    chk("rstmid_updo", 32'(updo), 32'd0);
    chk("rstmid_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 2 * NCH; a++) begin
      bus_rd(a);
      chk("rstmid_reg", 32'(updo), 32'd0);
    end

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      sta_vld = NCH'($urandom_range(0, (1 << NCH) - 1));
      sta_in  = $urandom;
      upen    = ($urandom_range(0, 3) != 0);
      uprs    = $urandom_range(0, 1) != 0;
      upws    = $urandom_range(0, 1) != 0;
      upa     = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, (1 << AW) - 1))
                                            : AW'($urandom_range(0, 2 * NCH - 1));
      updi    = WIDTH'($urandom);
      tick();
    end
    rst_n = 1'b1; sta_vld = '0; bus_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pstatus_bank.md
Name: pstatus_bank

Overview:
- Parametrised multi-channel status register bank for the microprocessor (up*) bus; successor to the single-channel read-only status macro.
- Each of NCH channels holds WIDTH status bits in one of two per-channel modes:
  - live: value follows the engine whenever its valid strobe is high.
  - sticky: bits accumulate until cleared by read-to-clear or write-1-to-clear.
- Adds a per-channel read/write interrupt mask and a registered interrupt output. Sits between the engine status outputs and the CPU register decoder.

Parameters:
- WIDTH, 8: bits per status channel.
- NCH, 4: number of channels; 1..16.
- AW, 5: address width; 2^AW must be >= 2*NCH, else elaboration error.
- STICKY, {NCH{1'b0}}: per-channel mode bit; 1 = sticky, 0 = live.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- sta_in  in  NCH*WIDTH  engine status; channel i occupies bits [i*WIDTH +: WIDTH].
- sta_vld  in  NCH  per-channel update strobe.
- upen  in  1  bus access enable.
- uprs  in  1  read select.
- upws  in  1  write select.
- upa  in  AW  register address.
- updi  in  WIDTH  write data.
- updo  out  WIDTH  registered read data.
- upack  out  1  access acknowledge.
- irq  out  1  OR of masked sticky bits.

Behaviour:
- Address map:
  - 0..NCH-1: status channel i.
  - NCH..2*NCH-1: mask of channel (upa-NCH).
  - All other addresses unmapped.
- Decode: rd_en = upen & uprs; wr_en = upen & upws & ~uprs. Read wins when both selects are high.
- upack <= rd_en | wr_en. Exactly one cycle after the access cycle, including unmapped addresses.
- updo:
  - On rd_en, updo <= pre-update value of the addressed register (status or mask); unmapped addresses return 0.
  - updo holds its value when there is no read.
- Live channel:
  - sta <= sta_vld[i] ? sta_in_i : sta.
  - Writes to its status address are acked and ignored.
  - No clear on read.
- Sticky channel:
  - set = sta_vld[i] ? sta_in_i : 0.
  - clr = (rd hit ? sta : 0) | (wr hit ? updi : 0).
  - sta <= (sta & ~clr) | set. Set wins over clear in the same cycle, so no event is lost.
  - Read-to-clear clears only the bits returned on updo.
- Mask: on a wr hit, mask <= updi. Mask is readable. The mask is WIDTH bits per channel, including live channels.
- irq <= |over sticky channels of (sta & mask). Registered; asserts one cycle after the sticky bit registers. Live channels never contribute to irq.
- Reset (rst_n low at a clk edge): sta, mask, updo, irq and upack all become 0.
  - Reset wins over any concurrent access or sta_vld.
  - An access presented in the reset cycle is not acked.
- Back-to-back accesses every cycle are legal, each acked on the following cycle. There are no wait states.

Decomposition:
- Package pstatus_pkg:
  - address-region constants (STA_BASE=0, MSK_BASE=NCH);
  - function addr_ok(upa, NCH);
  - elaboration check on AW.
- Sub-module pstatus_ch (WIDTH, STICKY_EN): one channel's status register, set/clear logic, mask register and irq term.
- The top level generates NCH instances, handles decode/ack, muxes updo and ORs the irq terms.

Test Plan:
- Live mode: WIDTH=8, NCH=4, STICKY=4'b0010.
  - Drive ch0 sta_in=0x5A with sta_vld=1 for one cycle, then sta_in=0xFF with sta_vld=0.
  - Read addr 0: updo=0x5A and upack=1 one cycle after the read.
  - A second read still returns 0x5A.
- Sticky accumulate and read-to-clear:
  - Pulse ch1 with 0x01, then 0x80.
  - Read addr 1: returns 0x81.
  - Immediate re-read: returns 0x00.
- Set-wins collision:
  - ch1 holds 0x03; read addr 1 in the same cycle as sta_vld with 0x02.
  - Read returns 0x03; next read returns 0x02.
- W1C and irq:
  - Write mask addr 5 = 0x0F; ch1 receives 0x0C.
  - irq rises 2 cycles after the sta_vld cycle.
  - Write addr 1 = 0x04: ch1 becomes 0x08 and irq stays 1.
  - Write addr 1 = 0x08: irq falls the cycle after ch1 clears.
- Unmapped and simultaneous selects:
  - Read addr 9: updo=0x00, upack=1.
  - upws=uprs=1 on addr 5: treated as a read, mask unchanged.
  - Write to live addr 0: acked, value unchanged.
- Reset mid-operation:
  - Assert rst_n=0 during a read of a sticky channel holding 0xAA.
  - Next cycle: upack=0, updo=0, irq=0, all sta=0, all mask=0.
